// File: rtl/i2c_xfer_pkg.sv
// Shared definitions for the I2C transfer sequencer: register map of the
// I2C master core, CMD/DATA/STATUS bit positions, response codes, FSM states
// and word-building helpers.
package i2c_xfer_pkg;

  // Word addresses of the I2C master core registers
  localparam logic [2:0] ADR_STATUS = 3'd0;
  localparam logic [2:0] ADR_CMD    = 3'd1;
  localparam logic [2:0] ADR_DATA   = 3'd2;

  // CMD register bit positions ([6:0] carries the device address)
  localparam int unsigned CMD_START_BIT = 32'd8;
  localparam int unsigned CMD_READ_BIT  = 32'd9;
  localparam int unsigned CMD_WM_BIT    = 32'd11;
  localparam int unsigned CMD_STOP_BIT  = 32'd12;

  // DATA register bit positions ([7:0] carries the byte)
  localparam int unsigned DATA_VALID_BIT = 32'd8;
  localparam int unsigned DATA_LAST_BIT  = 32'd9;

  // STATUS register bit positions
  localparam int unsigned STAT_BUSY_BIT = 32'd0;
  localparam int unsigned STAT_NACK_BIT = 32'd3;

  // Response codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LEN     = 2'd3;

  // Sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REG  = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_CMD_A   = 3'd3;
  localparam logic [2:0] ST_CMD_B   = 3'd4;
  localparam logic [2:0] ST_RD_DATA = 3'd5;
  localparam logic [2:0] ST_POLL    = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  // Build a CMD register word
  function automatic logic [15:0] cmd_word(input logic [6:0] dev, input logic start,
                                           input logic rd, input logic wm, input logic stop);
    logic [15:0] w;
    w                = 16'h0000;
    w[6:0]           = dev;
    w[CMD_START_BIT] = start;
    w[CMD_READ_BIT]  = rd;
    w[CMD_WM_BIT]    = wm;
    w[CMD_STOP_BIT]  = stop;
    return w;
  endfunction

  // Build a DATA register write word
  function automatic logic [15:0] data_word(input logic [7:0] b, input logic last);
    logic [15:0] w;
    w                = 16'h0000;
    w[7:0]           = b;
    w[DATA_LAST_BIT] = last;
    return w;
  endfunction

endpackage

// File: rtl/i2c_wbm_access.sv
// Single Wishbone access engine: latches one request on start, holds
// cyc/stb with stable address/data until ack, then returns the read word
// with a one-cycle done pulse. cyc/stb are low for at least the done cycle.
module i2c_wbm_access
  import i2c_xfer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  adr,
  input  logic [15:0] dat,
  input  logic        we,
  output logic        done,
  output logic [15:0] rdata,
  output logic [2:0]  wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  output logic        wbm_we_o,
  output logic [1:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic [15:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  logic        cyc_r;
  logic [2:0]  adr_r;
  logic [15:0] dat_r;
  logic        we_r;
  logic        done_r;
  logic [15:0] rdata_r;

  // Launch an access on start, retire it on ack; reset drops cyc/stb at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_r   <= 1'b0;
      adr_r   <= 3'd0;
      dat_r   <= 16'h0000;
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      rdata_r <= 16'h0000;
    end else begin
      done_r <= 1'b0;
      if (cyc_r) begin
        if (wbm_ack_i) begin
          cyc_r   <= 1'b0;
          done_r  <= 1'b1;
          rdata_r <= wbm_dat_i;
        end
      end else if (start) begin
        cyc_r <= 1'b1;
        adr_r <= adr;
        dat_r <= dat;
        we_r  <= we;
      end
    end
  end

  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = 2'b11;
  assign done      = done_r;
  assign rdata     = rdata_r;

endmodule

// File: rtl/i2c_xfer_seq.sv
// I2C register transfer sequencer: turns one read/write request of 1..4
// bytes into the CMD/DATA/STATUS access sequence of an I2C master core
// and reports completion with data and an error code.
module i2c_xfer_seq
  import i2c_xfer_pkg::*;
#(
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [6:0]  req_dev,
  input  logic [7:0]  req_reg,
  input  logic [2:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [2:0]  wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  output logic        wbm_we_o,
  output logic [1:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic [15:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  logic [2:0]  state_r;
  logic        busy_r;
  logic        rw_r;
  logic [6:0]  dev_r;
  logic [7:0]  reg_r;
  logic [2:0]  len_r;
  logic [31:0] wdata_r;
  logic [2:0]  idx_r;
  logic [15:0] poll_cnt_r;
  logic [31:0] rdata_r;
  logic [1:0]  err_r;

  logic        acc_start_s;
  logic [2:0]  acc_adr_s;
  logic [15:0] acc_dat_s;
  logic        acc_we_s;
  logic        acc_done_s;
  logic [15:0] acc_rdata_s;
  logic [7:0]  wbyte_s;
  logic        last_byte_s;
  logic [15:0] poll_nxt_s;
  logic [6:0]  unused_rdata_s;

  assign wbyte_s        = wdata_r[{idx_r[1:0], 3'b000} +: 8];
  assign last_byte_s    = (idx_r == (len_r - 3'd1));
  assign poll_nxt_s     = poll_cnt_r + 16'd1;
  assign unused_rdata_s = acc_rdata_s[15:9];

  // Select the access for the current state; a new one is issued whenever none is outstanding
  always_comb begin
    acc_start_s = 1'b0;
    acc_adr_s   = ADR_STATUS;
    acc_dat_s   = 16'h0000;
    acc_we_s    = 1'b0;
    case (state_r)
      ST_WR_REG: begin
        acc_start_s = ~busy_r;
        acc_adr_s   = ADR_DATA;
        acc_dat_s   = data_word(reg_r, rw_r);
        acc_we_s    = 1'b1;
      end
      ST_WR_DATA: begin
        acc_start_s = ~busy_r;
        acc_adr_s   = ADR_DATA;
        acc_dat_s   = data_word(wbyte_s, last_byte_s);
        acc_we_s    = 1'b1;
      end
      ST_CMD_A: begin
        acc_start_s = ~busy_r;
        acc_adr_s   = ADR_CMD;
        acc_dat_s   = cmd_word(dev_r, 1'b1, 1'b0, 1'b1, ~rw_r);
        acc_we_s    = 1'b1;
      end
      ST_CMD_B: begin
        acc_start_s = ~busy_r;
        acc_adr_s   = ADR_CMD;
        acc_dat_s   = cmd_word(dev_r, 1'b1, 1'b1, 1'b0, last_byte_s);
        acc_we_s    = 1'b1;
      end
      ST_RD_DATA: begin
        acc_start_s = ~busy_r;
        acc_adr_s   = ADR_DATA;
      end
      ST_POLL: begin
        acc_start_s = ~busy_r;
        acc_adr_s   = ADR_STATUS;
      end
      default: begin
        acc_start_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM: request capture, access sequencing, polling and completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      rw_r       <= 1'b0;
      dev_r      <= 7'd0;
      reg_r      <= 8'd0;
      len_r      <= 3'd0;
      wdata_r    <= 32'd0;
      idx_r      <= 3'd0;
      poll_cnt_r <= 16'd0;
      rdata_r    <= 32'd0;
      err_r      <= ERR_OK;
    end else begin
      if (acc_done_s) begin
        busy_r <= 1'b0;
      end else if (acc_start_s) begin
        busy_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            rw_r       <= req_rw;
            dev_r      <= req_dev;
            reg_r      <= req_reg;
            len_r      <= req_len;
            wdata_r    <= req_wdata;
            idx_r      <= 3'd0;
            poll_cnt_r <= 16'd0;
            rdata_r    <= 32'd0;
            if ((req_len == 3'd0) || (req_len > 3'd4)) begin
              err_r   <= ERR_LEN;
              state_r <= ST_DONE;
            end else begin
              err_r   <= ERR_OK;
              state_r <= ST_WR_REG;
            end
          end
        end
        ST_WR_REG: begin
          if (acc_done_s) begin
            idx_r   <= 3'd0;
            state_r <= rw_r ? ST_CMD_A : ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (acc_done_s) begin
            if (last_byte_s) begin
              idx_r   <= 3'd0;
              state_r <= ST_CMD_A;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        ST_CMD_A: begin
          if (acc_done_s) begin
            idx_r   <= 3'd0;
            state_r <= rw_r ? ST_CMD_B : ST_POLL;
          end
        end
        ST_CMD_B: begin
          if (acc_done_s) begin
            if (last_byte_s) begin
              idx_r   <= 3'd0;
              state_r <= ST_RD_DATA;
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        ST_RD_DATA: begin
          if (acc_done_s) begin
            poll_cnt_r <= poll_nxt_s;
            if (acc_rdata_s[DATA_VALID_BIT]) begin
              rdata_r[{idx_r[1:0], 3'b000} +: 8] <= acc_rdata_s[7:0];
            end
            if (acc_rdata_s[DATA_VALID_BIT] && last_byte_s) begin
              idx_r   <= 3'd0;
              state_r <= ST_POLL;
            end else if (poll_nxt_s >= POLL_LIMIT) begin
              err_r   <= ERR_TIMEOUT;
              state_r <= ST_DONE;
            end else if (acc_rdata_s[DATA_VALID_BIT]) begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        ST_POLL: begin
          if (acc_done_s) begin
            poll_cnt_r <= poll_nxt_s;
            if (!acc_rdata_s[STAT_BUSY_BIT]) begin
              err_r   <= acc_rdata_s[STAT_NACK_BIT] ? ERR_NACK : ERR_OK;
              state_r <= ST_DONE;
            end else if (poll_nxt_s >= POLL_LIMIT) begin
              err_r   <= ERR_TIMEOUT;
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign rsp_valid = (state_r == ST_DONE);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

  i2c_wbm_access u_access (
    .clk       (clk),
    .rst       (rst),
    .start     (acc_start_s),
    .adr       (acc_adr_s),
    .dat       (acc_dat_s),
    .we        (acc_we_s),
    .done      (acc_done_s),
    .rdata     (acc_rdata_s),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

endmodule
